// File: rtl/frame_receiver.sv
// frame_receiver: deserializes a 64-pixel serial stream into an 8x8 frame and scans it onto an LED matrix.
// Define FRAME_RX_DOUBLE_BUFFER_EN for separate capture/display buffers; default writes pixels straight to the display.
module frame_receiver #(
    parameter int SCAN_DIV = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] pixel_data,
    input  logic       frame_start,
    output logic [7:0] row_sel,
    output logic [7:0] col_data,
    output logic       busy,
    output logic       frame_done,
    output logic       frame_abort,
    output logic [7:0] frame_count
);
    typedef enum logic {IDLE, CAPTURE} state_t;
    state_t          state, state_next;
    logic [5:0]      idx;
    logic [7:0]      div_cnt;
    logic [2:0]      scan_row;
    logic [7:0][7:0] disp, src_buf, wr_buf;
    logic            wr_en, last, abort_hit, start_hit;
    logic            unused_pixel_bits;

    assign unused_pixel_bits = ^pixel_data[3:1];
    assign busy = (state == CAPTURE);

    always_comb begin
        state_next = state;
        wr_en = 1'b0;
        last = 1'b0;
        abort_hit = 1'b0;
        start_hit = 1'b0;
        if (state == IDLE) begin
            if (frame_start) begin
                start_hit = 1'b1;
                state_next = CAPTURE;
            end
        end else if (frame_start) begin
            abort_hit = 1'b1;
        end else begin
            wr_en = 1'b1;
            if (idx == 6'd63) begin
                last = 1'b1;
                state_next = IDLE;
            end
        end
    end

    // buffer contents with this cycle's pixel merged in, so commit sees pixel 63
    always_comb begin
        wr_buf = src_buf;
        if (wr_en) wr_buf[idx[5:3]][idx[2:0]] = pixel_data[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx <= '0;
            frame_done <= 1'b0;
            frame_abort <= 1'b0;
            frame_count <= '0;
        end else begin
            state <= state_next;
            idx <= (start_hit || abort_hit) ? 6'd0 : wr_en ? idx + 6'd1 : idx;
            frame_done <= last;
            frame_abort <= abort_hit;
            if (last) frame_count <= frame_count + 8'd1;
        end
    end

`ifdef FRAME_RX_DOUBLE_BUFFER_EN
    logic [7:0][7:0] cap_buf;
    assign src_buf = cap_buf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_buf <= '0;
            disp <= '0;
        end else begin
            cap_buf <= wr_buf;
            if (last) disp <= wr_buf;
        end
    end
`else
    assign src_buf = disp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) disp <= '0;
        else disp <= wr_buf;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            scan_row <= '0;
            row_sel <= 8'h01;
            col_data <= '0;
        end else begin
            if (div_cnt == 8'(SCAN_DIV - 1)) begin
                div_cnt <= '0;
                scan_row <= scan_row + 3'd1;
            end else begin
                div_cnt <= div_cnt + 8'd1;
            end
            row_sel <= 8'd1 << scan_row;
            col_data <= disp[scan_row];
        end
    end
endmodule

// File: tb/tb_frame_receiver.sv
// tb_frame_receiver: randomized directed checks of frame_receiver against a frame-level reference model.
module tb_frame_receiver;
    localparam int S = 4;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] pixel_data;
    logic       frame_start;
    logic [7:0] row_sel, col_data, frame_count;
    logic       busy, frame_done, frame_abort;

    int          errors = 0;
    int          checks = 0;
    int          ecnt;
    int          count_m = 0;
    logic [63:0] disp_m = '0;
    logic [63:0] fr_a, fr_b;

    frame_receiver #(.SCAN_DIV(S)) dut (
        .clk(clk), .rst_n(rst_n), .pixel_data(pixel_data), .frame_start(frame_start),
        .row_sel(row_sel), .col_data(col_data), .busy(busy), .frame_done(frame_done),
        .frame_abort(frame_abort), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    // edges since reset release; the scanned row follows from this alone
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ecnt <= 0;
        else ecnt <= ecnt + 1;
    end

    function automatic int cur_row();
        return (ecnt == 0) ? 0 : ((ecnt - 1) / S) % 8;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic fs, input logic pb);
        frame_start = fs;
        pixel_data = {3'($urandom), pb};
        @(posedge clk);
        #1;
        chk("row_sel", 32'(row_sel), 32'(8'd1 << cur_row()));
    endtask

    task automatic start(input logic in_capture);
        step(1'b1, 1'($urandom));
        chk("start_abort", 32'(frame_abort), 32'(in_capture));
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_done", 32'(frame_done), 32'd0);
    endtask

    task automatic pixels(input logic [63:0] pix, input int n);
        for (int k = 0; k < n; k++) begin
            step(1'b0, pix[k]);
`ifdef FRAME_RX_DOUBLE_BUFFER_EN
            chk("hold_display", 32'(col_data), 32'(disp_m[cur_row()*8 +: 8]));
`else
            disp_m[k] = pix[k];
`endif
            if (k == 63) begin
                count_m = (count_m + 1) % 256;
                disp_m = pix;
            end
            chk("done", 32'(frame_done), 32'(k == 63));
            chk("abort", 32'(frame_abort), 32'd0);
            chk("busy", 32'(busy), 32'(k != 63));
            chk("count", 32'(frame_count), 32'(count_m));
        end
    endtask

    task automatic idle_scan(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'($urandom));
            chk("col_data", 32'(col_data), 32'(disp_m[cur_row()*8 +: 8]));
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_pulse", 32'({frame_done, frame_abort}), 32'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        frame_start = 1'b0;
        pixel_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_row_sel", 32'(row_sel), 32'h01);
        chk("rst_col", 32'(col_data), 32'd0);
        chk("rst_count", 32'(frame_count), 32'd0);
        chk("rst_flags", 32'({busy, frame_done, frame_abort}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_scan(10);

        start(1'b0);
        pixels(64'd1 << 19, 64);
        idle_scan(8 * S + 2);

        start(1'b0);
        pixels('1, 64);
        idle_scan(8 * S + 2);

        fr_a = {$urandom, $urandom};
        for (int r = 0; r < 8; r++) fr_b[r*8 +: 8] = (r % 2 == 0) ? 8'h55 : 8'hAA;
        start(1'b0);
        pixels(fr_a, 30);
        start(1'b1);
        pixels(fr_b, 64);
        idle_scan(8 * S + 2);
        chk("checker_row1", 32'(disp_m[15:8]), 32'hAA);

        fr_a = {$urandom, $urandom};
        fr_b = {$urandom, $urandom};
        start(1'b0);
        pixels(fr_a, 64);
        start(1'b0);
        pixels(fr_b, 64);
        idle_scan(8 * S + 2);

        for (int f = count_m; f < 256; f++) begin
            start(1'b0);
            pixels({$urandom, $urandom}, 64);
        end
        chk("count_wrap", 32'(frame_count), 32'd0);
        idle_scan(S + 3);

        start(1'b0);
        pixels({$urandom, $urandom}, 20);
        #3;
        rst_n = 1'b0;
        #1;
        count_m = 0;
        disp_m = '0;
        chk("arst_row_sel", 32'(row_sel), 32'h01);
        chk("arst_col", 32'(col_data), 32'd0);
        chk("arst_count", 32'(frame_count), 32'd0);
        chk("arst_flags", 32'({busy, frame_done, frame_abort}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_scan(8 * S + 2);

        fr_a = {$urandom, $urandom};
        start(1'b0);
        pixels(fr_a, 64);
        idle_scan(8 * S + 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
